guess_judge: RTL and testbench

Game-control stage directly downstream of the 7-bit pseudo-random generator. On a new-game request it captures the generator's current output as the secret target, folded into 0..99. It then judges each submitted player guess as too high, too low or correct, and counts attempts against a configurable limit. Its registered flags drive the LED/seven-segment display logic.

---
 rtl/guess_pkg.sv | 29 ++
 rtl/rise_edge.sv | 32 +++
 rtl/guess_judge.sv | 176 +++++++++++++++++
 tb/tb_guess_judge.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Shared types and constants for the guessing-game judge.
// Holds the FSM state enum, datapath widths, target range limits and the
// helper that folds a raw 7-bit random value into the 0..99 target range.
package guess_pkg;

  localparam int unsigned GUESS_W    = 7;
  localparam int unsigned TRIES_W    = 4;
  localparam int unsigned TARGET_MAX = 99;
  localparam int unsigned FOLD_SUB   = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_e;

  // 0..127 folded into 0..99; a single subtract suffices because 127-100 < 100
  function automatic logic [GUESS_W-1:0] fold_target(input logic [GUESS_W-1:0] raw);
    logic [GUESS_W-1:0] res;
    if (raw >= GUESS_W'(FOLD_SUB)) begin
      res = raw - GUESS_W'(FOLD_SUB);
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector: one previous-sample flop plus an AND gate.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-low
//   din    - level input (already synchronised/debounced upstream)
//   rise_c - combinational pulse, high for the cycle din is first seen high
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_c
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  // Previous-sample register
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_c = din & ~prev_q;

endmodule

// File: rtl/guess_judge.sv
// Guessing-game judge: captures a folded random target on newgame, then
// grades each submitted guess and counts attempts against MAX_TRIES.
// Optional feature macro: GUESS_REVEAL_EN adds the reveal port.
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   rand_in[6:0]        - live pseudo-random value
//   newgame, submit     - level inputs, acted on at their rising edge
//   guess[6:0]          - player guess
//   too_high, too_low   - hint flags for the last valid guess
//   win, lose           - game outcome flags
//   invalid             - last submitted guess was out of range (> 99)
//   tries[3:0]          - counted guesses in the current game
//   playing             - high while a game is in progress
//   reveal[6:0]         - target shown after the game ends (GUESS_REVEAL_EN)
module guess_judge
  import guess_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [GUESS_W-1:0] rand_in,
  input  logic               newgame,
  input  logic [GUESS_W-1:0] guess,
  input  logic               submit,
  output logic               too_high,
  output logic               too_low,
  output logic               win,
  output logic               lose,
  output logic               invalid,
  output logic [TRIES_W-1:0] tries,
  output logic               playing
`ifdef GUESS_REVEAL_EN
  ,
  output logic [GUESS_W-1:0] reveal
`endif
);

  localparam logic [TRIES_W-1:0] MAX_TRIES_C = TRIES_W'(MAX_TRIES);

  logic newgame_rise_c;
  logic submit_rise_c;

  state_e             state_q,    state_d;
  logic [GUESS_W-1:0] target_q,   target_d;
  logic [TRIES_W-1:0] tries_q,    tries_d;
  logic               too_high_q, too_high_d;
  logic               too_low_q,  too_low_d;
  logic               win_q,      win_d;
  logic               lose_q,     lose_d;
  logic               invalid_q,  invalid_d;
  logic               playing_q,  playing_d;
  logic [TRIES_W-1:0] tries_inc_c;

  rise_edge u_newgame_edge (
    .clk    (clk),
    .reset  (reset),
    .din    (newgame),
    .rise_c (newgame_rise_c)
  );

  rise_edge u_submit_edge (
    .clk    (clk),
    .reset  (reset),
    .din    (submit),
    .rise_c (submit_rise_c)
  );

  assign tries_inc_c = tries_q + TRIES_W'(1);

  // Next-state and flag logic; newgame has priority over a coincident submit
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    tries_d    = tries_q;
    too_high_d = too_high_q;
    too_low_d  = too_low_q;
    win_d      = win_q;
    lose_d     = lose_q;
    invalid_d  = invalid_q;

    if (newgame_rise_c) begin
      state_d    = PLAY;
      target_d   = fold_target(rand_in);
      tries_d    = '0;
      too_high_d = 1'b0;
      too_low_d  = 1'b0;
      win_d      = 1'b0;
      lose_d     = 1'b0;
      invalid_d  = 1'b0;
    end else if (submit_rise_c && (state_q == PLAY)) begin
      if (guess > GUESS_W'(TARGET_MAX)) begin
        // Out-of-range guess is flagged but not counted
        invalid_d  = 1'b1;
        too_high_d = 1'b0;
        too_low_d  = 1'b0;
      end else begin
        invalid_d = 1'b0;
        tries_d   = tries_inc_c;
        if (guess == target_q) begin
          state_d    = WIN;
          win_d      = 1'b1;
          too_high_d = 1'b0;
          too_low_d  = 1'b0;
        end else if (tries_inc_c == MAX_TRIES_C) begin
          state_d    = LOSE;
          lose_d     = 1'b1;
          too_high_d = 1'b0;
          too_low_d  = 1'b0;
        end else begin
          too_high_d = (guess > target_q);
          too_low_d  = (guess < target_q);
        end
      end
    end

    // Registered decode so playing tracks the state it reports
    playing_d = (state_d == PLAY);
  end

  // Main state and flag registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      target_q   <= '0;
      tries_q    <= '0;
      too_high_q <= 1'b0;
      too_low_q  <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      invalid_q  <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      tries_q    <= tries_d;
      too_high_q <= too_high_d;
      too_low_q  <= too_low_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      invalid_q  <= invalid_d;
      playing_q  <= playing_d;
    end
  end

  assign too_high = too_high_q;
  assign too_low  = too_low_q;
  assign win      = win_q;
  assign lose     = lose_q;
  assign invalid  = invalid_q;
  assign tries    = tries_q;
  assign playing  = playing_q;

`ifdef GUESS_REVEAL_EN
  logic [GUESS_W-1:0] reveal_q, reveal_d;

  // Target is exposed only once the game has ended
  always_comb begin
    reveal_d = '0;
    if ((state_d == WIN) || (state_d == LOSE)) begin
      reveal_d = target_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      reveal_q <= '0;
    end else begin
      reveal_q <= reveal_d;
    end
  end

  assign reveal = reveal_q;
`endif

endmodule

// File: tb/tb_guess_judge.sv
// Self-checking bench for guess_judge: directed scenarios plus a randomized
// run, all compared against a behavioural game model.
module tb_guess_judge;

  localparam int unsigned MAX_TRIES = 7;

  logic       clk;
  logic       reset;
  logic [6:0] rand_in;
  logic       newgame;
  logic [6:0] guess;
  logic       submit;
  logic       too_high, too_low, win, lose, invalid, playing;
  logic [3:0] tries;
`ifdef GUESS_REVEAL_EN
  logic [6:0] reveal;
`endif

  int checks;
  int failures;

  // Behavioural model of the game
  int m_target;
  int m_tries;
  bit m_playing, m_won, m_lost, m_hi, m_lo, m_inv;

  guess_judge #(.MAX_TRIES(MAX_TRIES)) dut (
    .clk      (clk),
    .reset    (reset),
    .rand_in  (rand_in),
    .newgame  (newgame),
    .guess    (guess),
    .submit   (submit),
    .too_high (too_high),
    .too_low  (too_low),
    .win      (win),
    .lose     (lose),
    .invalid  (invalid),
    .tries    (tries),
    .playing  (playing)
`ifdef GUESS_REVEAL_EN
    ,
    .reveal   (reveal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_target = 0; m_tries = 0;
    m_playing = 0; m_won = 0; m_lost = 0; m_hi = 0; m_lo = 0; m_inv = 0;
  endfunction

  function automatic void model_newgame(input int r);
    m_target = r % 100;
    m_tries = 0;
    m_playing = 1; m_won = 0; m_lost = 0; m_hi = 0; m_lo = 0; m_inv = 0;
  endfunction

  function automatic void model_submit(input int g);
    if (!m_playing) return;
    if (g > 99) begin
      m_inv = 1; m_hi = 0; m_lo = 0;
      return;
    end
    m_inv = 0;
    m_tries = m_tries + 1;
    if (g == m_target) begin
      m_won = 1; m_playing = 0; m_hi = 0; m_lo = 0;
    end else if (m_tries == MAX_TRIES) begin
      m_lost = 1; m_playing = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_hi = (g > m_target);
      m_lo = (g < m_target);
    end
  endfunction

  function automatic logic [16:0] obs_vec();
    logic [6:0] rv;
    rv = '0;
`ifdef GUESS_REVEAL_EN
    rv = reveal;
`endif
    return {too_high, too_low, win, lose, invalid, tries, playing, rv};
  endfunction

  function automatic logic [16:0] exp_vec();
    logic [6:0] rv;
    logic [3:0] t;
    logic [6:0] tg;
    rv = '0;
    t = 4'(m_tries);
    tg = 7'(m_target);
`ifdef GUESS_REVEAL_EN
    if (m_won || m_lost) rv = tg;
`endif
    return {m_hi, m_lo, m_won, m_lost, m_inv, t, m_playing, rv};
  endfunction

  // One newgame pulse; outputs are valid at the returning negedge
  task automatic do_newgame(input int r);
    @(negedge clk);
    rand_in = 7'(r); newgame = 1'b1;
    @(negedge clk);
    newgame = 1'b0;
    rand_in = 7'($urandom_range(0, 127));
    model_newgame(r);
  endtask

  // One submit pulse with a scrambled rand_in to prove the target holds
  task automatic do_submit(input int g);
    @(negedge clk);
    guess = 7'(g); submit = 1'b1;
    rand_in = 7'($urandom_range(0, 127));
    @(negedge clk);
    submit = 1'b0;
    model_submit(g);
  endtask

  task automatic test_reset();
    reset = 1'b0; newgame = 1'b0; submit = 1'b0; guess = '0; rand_in = '0;
    repeat (3) @(negedge clk);
    model_reset();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset: got %h expected %h", obs_vec(), exp_vec());
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL idle_after_reset: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    int gl[3] = '{50, 30, 42};
    do_newgame(42);
    checks++;
    if (playing !== 1'b1 || tries !== 4'd0) begin
      failures++;
      $display("FAIL basic_start: got playing=%b tries=%0d expected playing=1 tries=0", playing, tries);
    end
    foreach (gl[i]) begin
      do_submit(gl[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL basic_guess_%0d: got %h expected %h", gl[i], obs_vec(), exp_vec());
      end
    end
    checks++;
    if (win !== 1'b1 || tries !== 4'd3 || playing !== 1'b0) begin
      failures++;
      $display("FAIL basic_win: got win=%b tries=%0d playing=%b expected win=1 tries=3 playing=0", win, tries, playing);
    end
  endtask

  task automatic test_fold();
    do_newgame(117);
    do_submit(17);
    checks++;
    if (win !== 1'b1 || tries !== 4'd1) begin
      failures++;
      $display("FAIL fold_117: got win=%b tries=%0d expected win=1 tries=1", win, tries);
    end
    do_newgame(100);
    do_submit(0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL fold_100: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_lose();
    do_newgame(10);
    for (int i = 0; i < MAX_TRIES; i++) begin
      do_submit(11);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL lose_try_%0d: got %h expected %h", i + 1, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (lose !== 1'b1 || too_high !== 1'b0 || tries !== 4'(MAX_TRIES)) begin
      failures++;
      $display("FAIL lose_final: got lose=%b too_high=%b tries=%0d expected lose=1 too_high=0 tries=%0d",
               lose, too_high, tries, MAX_TRIES);
    end
    do_submit(10);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL lose_extra_submit: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_invalid();
    do_newgame(60);
    do_submit(70);
    do_submit(120);
    checks++;
    if (invalid !== 1'b1 || tries !== 4'd1 || too_high !== 1'b0) begin
      failures++;
      $display("FAIL invalid_120: got invalid=%b tries=%0d too_high=%b expected 1/1/0", invalid, tries, too_high);
    end
    do_submit(5);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL invalid_clear: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    do_newgame(42);
    do_submit(1); do_submit(2); do_submit(3);
    checks++;
    if (tries !== 4'd3) begin
      failures++;
      $display("FAIL simul_setup: got tries=%0d expected 3", tries);
    end
    @(negedge clk);
    rand_in = 7'd88; newgame = 1'b1; guess = 7'd5; submit = 1'b1;
    @(negedge clk);
    newgame = 1'b0; submit = 1'b0;
    model_newgame(88);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL simul_newgame_submit: got %h expected %h", obs_vec(), exp_vec());
    end
    do_submit(88);
    checks++;
    if (win !== 1'b1) begin
      failures++;
      $display("FAIL simul_new_target: got win=%b expected 1", win);
    end
  endtask

  task automatic test_hold();
    do_newgame(20);
    @(negedge clk);
    guess = 7'd30; submit = 1'b1;
    repeat (10) @(negedge clk);
    submit = 1'b0;
    model_submit(30);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL hold_submit: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_mid_reset();
    do_newgame(50);
    for (int i = 0; i < 4; i++) do_submit(i);
    checks++;
    if (tries !== 4'd4) begin
      failures++;
      $display("FAIL midreset_setup: got tries=%0d expected 4", tries);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL mid_reset: got %h expected %h", obs_vec(), exp_vec());
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int g;
    int r;
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        r = int'($urandom_range(0, 127));
        do_newgame(r);
      end else begin
        g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 99));
        do_submit(g);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        bad++;
        if (bad <= 10) $display("FAIL random_op_%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_basic();
    test_fold();
    test_lose();
    test_invalid();
    test_simultaneous();
    test_hold();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
